// File: rtl/mdu_seq_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_seq_pkg;

    localparam int MDU_DW = 32;

    localparam logic [1:0] MDU_MULT  = 2'd0;
    localparam logic [1:0] MDU_MULTU = 2'd1;
    localparam logic [1:0] MDU_DIV   = 2'd2;
    localparam logic [1:0] MDU_DIVU  = 2'd3;

    localparam logic [1:0] MDU_IDLE = 2'd0;
    localparam logic [1:0] MDU_RUN  = 2'd1;
    localparam logic [1:0] MDU_FIX  = 2'd2;

endpackage

// File: rtl/mdu_seq_if.sv
// Pipeline-side bundle of the MDU: op launch, squash, MTHI/MTLO and HI/LO results.
interface mdu_seq_if #(parameter int DATA_WIDTH = 32);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  flush;
    logic                  hi_we;
    logic                  lo_we;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport slave (input start, op, a, b, flush, hi_we, lo_we, wdata,
                   output busy, done, hi, lo);
    modport master (output start, op, a, b, flush, hi_we, lo_we, wdata,
                    input busy, done, hi, lo);
endinterface

// File: rtl/mdu_seq_step.sv
// One shift-add (multiply) or restoring-divide iteration around a single adder/subtractor.
module mdu_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0]   opd,
    input  logic                    div,
    output logic [2*DATA_WIDTH-1:0] acc_next
);
    localparam int W = DATA_WIDTH;

    logic [W+1:0] lhs, rhs, sum;

    // Two guard bits so the divide sign test is unambiguous for a W+1 bit partial remainder.
    always_comb begin
        lhs = div ? {1'b0, acc[2*W-1:W-1]} : {2'b00, acc[2*W-1:W]};
        rhs = div ? ~{2'b00, opd} : {2'b00, opd};
        sum = lhs + rhs + {{(W+1){1'b0}}, div};
        if (div) begin
            if (!sum[W+1])
                acc_next = {sum[W-1:0], acc[W-2:0], 1'b1};
            else
                acc_next = {acc[2*W-2:0], 1'b0};
        end else begin
            if (acc[0])
                acc_next = {sum[W:0], acc[W-1:1]};
            else
                acc_next = {1'b0, acc[2*W-1:1]};
        end
    end
endmodule

// File: rtl/mdu_seq.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO: IDLE -> RUN (DATA_WIDTH steps) -> FIX -> IDLE.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_DW
) (
    input logic        clk,
    input logic        rst_n,
    mdu_seq_if.slave   bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    logic [1:0]     state;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc, acc_next, prod_fix;
    logic [W-1:0]   opd, hi_q, lo_q, abs_a, abs_b, q_fix, r_fix;
    logic           is_div, is_signed, sa, sb, divz, done_q;
    logic           op_div, op_signed;

    assign op_div    = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
    assign op_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
    assign abs_a     = (op_signed && bus.a[W-1]) ? -bus.a : bus.a;
    assign abs_b     = (op_signed && bus.b[W-1]) ? -bus.b : bus.b;

    mdu_step #(.DATA_WIDTH(W)) u_step (
        .acc      (acc),
        .opd      (opd),
        .div      (is_div),
        .acc_next (acc_next)
    );

    // Divide by zero keeps the all-ones quotient, while the remainder sign fix turns |a| back into a.
    always_comb begin
        prod_fix = acc;
        q_fix    = acc[W-1:0];
        r_fix    = acc[2*W-1:W];
        if (is_signed && (sa ^ sb)) prod_fix = -acc;
        if (is_signed && (sa ^ sb) && !divz) q_fix = -acc[W-1:0];
        if (is_signed && sa) r_fix = -acc[2*W-1:W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MDU_IDLE;
            cnt       <= '0;
            acc       <= '0;
            opd       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            divz      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == MDU_IDLE) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
            if (bus.flush) begin
                state <= MDU_IDLE;
            end else begin
                case (state)
                    MDU_IDLE: if (bus.start) begin
                        is_div    <= op_div;
                        is_signed <= op_signed;
                        sa        <= op_signed && bus.a[W-1];
                        sb        <= op_signed && bus.b[W-1];
                        divz      <= (abs_b == '0);
                        opd       <= op_div ? abs_b : abs_a;
                        acc       <= {{W{1'b0}}, (op_div ? abs_a : abs_b)};
                        cnt       <= CW'(W - 1);
                        state     <= MDU_RUN;
                    end
                    MDU_RUN: begin
                        acc <= acc_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) state <= MDU_FIX;
                    end
                    MDU_FIX: begin
                        if (is_div) begin
                            hi_q <= r_fix;
                            lo_q <= q_fix;
                        end else begin
                            hi_q <= prod_fix[2*W-1:W];
                            lo_q <= prod_fix[W-1:0];
                        end
                        done_q <= 1'b1;
                        state  <= MDU_IDLE;
                    end
                    default: state <= MDU_IDLE;
                endcase
            end
        end
    end

    assign bus.busy = (state != MDU_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq with hand-computed HI/LO results.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mdu_seq_if #(.DATA_WIDTH(32)) bus ();

    mdu_seq #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launches one op at a negedge; poke>0 re-pulses start every poke cycles while busy.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke, output int cyc, output int busyc, output int donec);
        cyc = 0; busyc = 0; donec = 0;
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            bus.start = (poke > 0 && cyc < 30 && (cyc % poke) == 0);
            bus.a = ~a; bus.b = b + 32'd5; bus.op = ~op;
            if (bus.busy) busyc++;
            if (bus.done) donec++;
        end while (!bus.done && cyc < 100);
        bus.start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy) busyc++;
            if (bus.done) donec++;
        end
    endtask

    int cyc, busyc, donec;

    initial begin
        bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
        bus.flush = 0; bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
        #7;
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        run_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, cyc, busyc, donec);
        chk("multu_lat", 64'(cyc), 64'd34);
        chk("multu_busy", 64'(busyc), 64'd33);
        chk("multu_done", 64'(donec), 64'd1);
        chk("multu_res", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);

        run_op(MDU_MULT, 32'hFFFFFFFD, 32'd7, 0, cyc, busyc, donec);
        chk("mult_res", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);

        run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, 0, cyc, busyc, donec);
        chk("div_res", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);

        run_op(MDU_DIVU, 32'd100, 32'd0, 0, cyc, busyc, donec);
        chk("divu_z", {bus.hi, bus.lo}, 64'h00000064_FFFFFFFF);

        run_op(MDU_DIV, 32'hFFFFFFFB, 32'd0, 0, cyc, busyc, donec);
        chk("div_z", {bus.hi, bus.lo}, 64'hFFFFFFFB_FFFFFFFF);

        run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 0, cyc, busyc, donec);
        chk("div_wrap", {bus.hi, bus.lo}, 64'h00000000_80000000);

        run_op(MDU_DIVU, 32'd1000, 32'd7, 0, cyc, busyc, donec);
        chk("divu_res", {bus.hi, bus.lo}, 64'h00000006_0000008E);

        // start pulses while busy must not disturb or queue
        run_op(MDU_MULTU, 32'd6, 32'd7, 5, cyc, busyc, donec);
        chk("nq_res", {bus.hi, bus.lo}, 64'h00000000_0000002A);
        chk("nq_done", 64'(donec), 64'd1);
        chk("nq_idle", {63'd0, bus.busy}, 64'd0);

        // MTHI/MTLO in IDLE, then flush mid-RUN
        bus.hi_we = 1; bus.wdata = 32'h11;
        @(negedge clk);
        bus.hi_we = 0; bus.lo_we = 1; bus.wdata = 32'h22;
        @(negedge clk);
        bus.lo_we = 0;
        chk("mt_hilo", {bus.hi, bus.lo}, 64'h00000011_00000022);
        bus.op = MDU_DIV; bus.a = 32'd50; bus.b = 32'd3; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        repeat (10) @(negedge clk);
        chk("fl_busy_pre", {63'd0, bus.busy}, 64'd1);
        bus.flush = 1;
        @(negedge clk);
        bus.flush = 0;
        chk("fl_busy", {63'd0, bus.busy}, 64'd0);
        donec = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) donec++;
        end
        chk("fl_nodone", 64'(donec), 64'd0);
        chk("fl_hilo", {bus.hi, bus.lo}, 64'h00000011_00000022);
        run_op(MDU_DIV, 32'd50, 32'hFFFFFFFD, 0, cyc, busyc, donec);
        chk("fl_fresh", {bus.hi, bus.lo}, 64'h00000002_FFFFFFF0);

        // MTLO in IDLE lands; MTLO while busy is dropped
        bus.lo_we = 1; bus.wdata = 32'hABCD;
        @(negedge clk);
        bus.lo_we = 0;
        chk("mtlo", {32'd0, bus.lo}, 64'h0000ABCD);
        bus.op = MDU_MULTU; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        bus.lo_we = 1; bus.wdata = 32'h5555;
        @(negedge clk);
        bus.lo_we = 0;
        chk("mtlo_busy", {32'd0, bus.lo}, 64'h0000ABCD);

        // asynchronous reset off the clock edge, mid-RUN
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", {63'd0, bus.busy}, 64'd0);
        chk("ar_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("ar_idle", {63'd0, bus.busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
